// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and line levels for the serial transmitter
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - free-running bit-period counter, ticks on the last cycle of each bit
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned   CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == LAST);

  // Wrapping on tick keeps consecutive data bits aligned without an explicit clear.
  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - parallel-in, serial-out frame transmitter (start, data, stop)
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          LSB_FIRST    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid,
  output logic                  ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned    BCW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_adv;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  tick, accept, timer_clear;

  function automatic logic out_bit(input logic [DATA_WIDTH-1:0] v);
    return LSB_FIRST ? v[0] : v[DATA_WIDTH-1];
  endfunction

  assign ready       = (state_q == IDLE);
  assign busy        = ~ready;
  assign tx          = tx_q;
  assign done        = done_q;
  assign accept      = valid & ready;
  assign shift_adv   = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
  assign timer_clear = accept | (state_d != state_q);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .clear(timer_clear),
    .tick (tick)
  );

  // tx_d anticipates the level of the next cycle so the line comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d   = START;
          shift_d   = data_in;
          bit_cnt_d = '0;
          tx_d      = START_LEVEL;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = out_bit(shift_q);
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = IDLE_LEVEL;
          end else begin
            shift_d   = shift_adv;
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = out_bit(shift_adv);
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          tx_d    = IDLE_LEVEL;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= IDLE_LEVEL;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

endmodule
